// File: rtl/mux_scan_pipe.sv
// -----------------------------------------------------------------------------
// mux_scan_pipe
//
// This module is an N-channel, W-bit selector with a registered output and a
// valid/ready handshake. It is the sequential successor to the gate-level 16:1
// enabled selector.
//
// Operating modes:
//   direct (mode = 0) : the external select "sel" picks the channel.
//   scan   (mode = 1) : an internal round-robin pointer walks the channels
//                       enabled in "mask". The pointer advances past each
//                       captured channel.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   global enable; 0 blocks new captures
//   mode       in   0 = direct select, 1 = round-robin scan
//   sel        in   channel index used in direct mode
//   mask       in   per-channel enable used in scan mode (bit i = channel i)
//   din        in   channel data; channel i at bits [i*W +: W]
//   out_ready  in   consumer accepts dout this cycle
//   out_valid  out  dout/out_ch hold a sample
//   dout       out  captured sample
//   out_ch     out  channel index of the captured sample
//   sel_err    out  one-cycle pulse when direct mode sees sel >= NCH
// -----------------------------------------------------------------------------
module mux_scan_pipe #(
   parameter int NCH  = 16,
   parameter int W    = 1,
   parameter int SELW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [NCH-1:0]    mask,
   input  logic [NCH*W-1:0]  din,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [W-1:0]      dout,
   output logic [SELW-1:0]   out_ch,
   output logic              sel_err
);

   // NCH expressed at SELW+1 bits, so that index arithmetic never overflows.
   localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

   if (SELW != $clog2(NCH) || NCH < 2 || NCH > 64 || W < 1 || W > 64) begin : g_param_check
      $error("mux_scan_pipe: SELW must equal clog2(NCH), NCH in 2..64, W in 1..64");
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic              out_valid_q, out_valid_d;
   logic [W-1:0]      dout_q,      dout_d;
   logic [SELW-1:0]   out_ch_q,    out_ch_d;
   logic              sel_err_q,   sel_err_d;
   logic [SELW-1:0]   ptr_q,       ptr_d;

   // ---------------------------------------------------------------------------
   // Scan search. The mask is rotated so that ptr sits at bit 0. A priority
   // encoder then finds the lowest set bit, and the offset is rotated back.
   // ---------------------------------------------------------------------------
   logic [NCH-1:0]    rot_mask;
   logic              scan_hit;
   logic [SELW-1:0]   scan_off;
   logic [SELW:0]     scan_sum;
   logic [SELW-1:0]   scan_ch;
   logic [SELW:0]     ptr_inc;
   logic [SELW-1:0]   ptr_next;

   always_comb begin
      rot_mask = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         rot_mask[k] = mask[(32'(ptr_q) + k) % NCH];
      end
   end

   always_comb begin
      scan_hit = 1'b0;
      scan_off = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (!scan_hit && rot_mask[k]) begin
            scan_hit = 1'b1;
            scan_off = SELW'(k);
         end
      end
   end

   always_comb begin
      scan_sum = {1'b0, ptr_q} + {1'b0, scan_off};
      if (scan_sum >= NCH_W) begin
         scan_sum = scan_sum - NCH_W;
      end
      scan_ch = scan_sum[SELW-1:0];

      // The pointer moves to the channel just after the one captured,
      // wrapping at NCH.
      ptr_inc = {1'b0, scan_ch} + 1'b1;
      if (ptr_inc == NCH_W) begin
         ptr_inc = '0;
      end
      ptr_next = ptr_inc[SELW-1:0];
   end

   // ---------------------------------------------------------------------------
   // Channel choice and data selection
   // ---------------------------------------------------------------------------
   logic              sel_ok;
   logic              pick_ok;
   logic [SELW-1:0]   pick_ch;
   logic [W-1:0]      pick_data;
   logic              slot_free;
   logic              capture;

   always_comb begin
      sel_ok    = ({1'b0, sel} < NCH_W);
      pick_ok   = mode ? scan_hit : sel_ok;
      pick_ch   = mode ? scan_ch  : sel;
      slot_free = !out_valid_q || out_ready;
      capture   = en && slot_free && pick_ok;
   end

   always_comb begin
      pick_data = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (pick_ch == SELW'(k)) begin
            pick_data = din[k*W +: W];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      // An error is flagged only when a direct-mode capture would otherwise
      // have been taken.
      sel_err_d   = !mode && en && slot_free && !sel_ok;

      if (capture) begin
         out_valid_d = 1'b1;
         dout_d      = pick_data;
         out_ch_d    = pick_ch;
         if (mode) begin
            ptr_d = ptr_next;
         end
      end else if (slot_free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         out_ch_q    <= '0;
         sel_err_q   <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         out_ch_q    <= out_ch_d;
         sel_err_q   <= sel_err_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_ch    = out_ch_q;
   assign sel_err   = sel_err_q;

endmodule
